// File: rtl/seq_dp_pkg.sv
// Shared types and constants for the self-sequencing datapath.
package seq_dp_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_WRITE
    } state_e;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

endpackage

// File: rtl/seq_dp_regfile.sv
// Register file: one write port, combinational operand and debug read ports.
module seq_dp_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [NREGS-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  mem        <= '0;
        else if (we) mem[waddr] <= wdata;
    end

    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing datapath: one command per start/done handshake.
// Optional macro SEQ_DATAPATH_NV_FLAGS_EN adds N and V status flags.
module seq_datapath
    import seq_dp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    parameter  int IMM_W = 5,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    output logic             done,
    input  logic [AW-1:0]    rn,
    input  logic [AW-1:0]    rm,
    input  logic [AW-1:0]    rd,
    input  logic [1:0]       alu_op,
    input  logic [1:0]       shift,
    input  logic             asel,
    input  logic             bsel,
    input  logic             vsel,
    input  logic             wb_en,
    input  logic             set_flags,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] ext_in,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       status,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_e state_q, state_d;
    logic   accept, rf_we;

    logic [AW-1:0]    rn_q, rm_q, rd_q;
    alu_op_e          op_q;
    shift_e           sh_q;
    logic             asel_q, bsel_q, vsel_q, wb_q, sf_q;
    logic [IMM_W-1:0] imm_q;
    logic [WIDTH-1:0] ext_q;

    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       stat_q, stat_nxt;
    logic             done_q;

    logic [WIDTH-1:0] rf_rdata, ain, bin, alu_res;

    function automatic logic [WIDTH-1:0] shift_fn(input shift_e s, input logic [WIDTH-1:0] v);
        unique case (s)
            SH_LSL1: shift_fn = {v[WIDTH-2:0], 1'b0};
            SH_LSR1: shift_fn = {1'b0, v[WIDTH-1:1]};
            SH_ASR1: shift_fn = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_fn = v;
        endcase
    endfunction

    // Operand fetch reuses one read port: rn while in LOAD_A, rm otherwise.
    seq_dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (vsel_q ? ext_q : c_q),
        .raddr    ((state_q == S_LOAD_A) ? rn_q : rm_q),
        .rdata    (rf_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        rf_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = vsel ? S_WRITE : S_LOAD_A;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_WRITE;
            S_WRITE: begin
                rf_we   = wb_q;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ain      = asel_q ? '0 : a_q;
        bin      = bsel_q ? {{(WIDTH-IMM_W){1'b0}}, imm_q} : shift_fn(sh_q, b_q);
        alu_res  = '0;
        stat_nxt = '0;
        unique case (op_q)
            ALU_ADD:  alu_res = ain + bin;
            ALU_SUB:  alu_res = ain - bin;
            ALU_AND:  alu_res = ain & bin;
            ALU_NOTB: alu_res = ~bin;
            default:  alu_res = '0;
        endcase
        stat_nxt[STAT_Z] = (alu_res == '0);
`ifdef SEQ_DATAPATH_NV_FLAGS_EN
        stat_nxt[STAT_N] = alu_res[WIDTH-1];
        unique case (op_q)
            ALU_ADD: stat_nxt[STAT_V] = (ain[WIDTH-1] == bin[WIDTH-1]) &&
                                        (alu_res[WIDTH-1] != ain[WIDTH-1]);
            ALU_SUB: stat_nxt[STAT_V] = (ain[WIDTH-1] != bin[WIDTH-1]) &&
                                        (alu_res[WIDTH-1] != ain[WIDTH-1]);
            default: stat_nxt[STAT_V] = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rn_q   <= '0;
            rm_q   <= '0;
            rd_q   <= '0;
            op_q   <= ALU_ADD;
            sh_q   <= SH_NONE;
            asel_q <= 1'b0;
            bsel_q <= 1'b0;
            vsel_q <= 1'b0;
            wb_q   <= 1'b0;
            sf_q   <= 1'b0;
            imm_q  <= '0;
            ext_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            stat_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (accept) begin
                rn_q   <= rn;
                rm_q   <= rm;
                rd_q   <= rd;
                op_q   <= alu_op_e'(alu_op);
                sh_q   <= shift_e'(shift);
                asel_q <= asel;
                bsel_q <= bsel;
                vsel_q <= vsel;
                wb_q   <= wb_en;
                sf_q   <= set_flags;
                imm_q  <= imm;
                ext_q  <= ext_in;
            end
            if (state_q == S_LOAD_A) a_q <= rf_rdata;
            if (state_q == S_LOAD_B) b_q <= rf_rdata;
            if (state_q == S_EXEC) begin
                c_q <= alu_res;
                if (sf_q) stat_q <= stat_nxt;
            end
            done_q <= (state_q == S_WRITE);
        end
    end

    assign done   = done_q;
    assign result = c_q;
    assign status = stat_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench: random commands checked against an arithmetic reference model.
module tb_seq_datapath;
    localparam int W  = 16;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int IW = 5;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 0, ready, done, asel = 0, bsel = 0, vsel = 0, wb_en = 0, set_flags = 0;
    logic [AW-1:0] rn = 0, rm = 0, rd = 0, dbg_addr = 0;
    logic [1:0]    alu_op = 0, shift = 0;
    logic [IW-1:0] imm = 0;
    logic [W-1:0]  ext_in = 0, result, dbg_data;
    logic [2:0]    status;

    seq_datapath #(.WIDTH(W), .NREGS(N), .IMM_W(IW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .done(done),
        .rn(rn), .rm(rm), .rd(rd), .alu_op(alu_op), .shift(shift), .asel(asel),
        .bsel(bsel), .vsel(vsel), .wb_en(wb_en), .set_flags(set_flags), .imm(imm),
        .ext_in(ext_in), .result(result), .status(status), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    // Narrow instance: WIDTH=8, NREGS=4
    logic       start8 = 0, ready8, done8, vsel8 = 0;
    logic [1:0] rn8 = 0, rm8 = 0, rd8 = 0, op8 = 0, sh8 = 0, dbg_addr8 = 0;
    logic [4:0] imm8 = 0;
    logic [7:0] ext8 = 0, result8, dbg_data8;
    logic [2:0] status8;

    seq_datapath #(.WIDTH(8), .NREGS(4), .IMM_W(5)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ready(ready8), .done(done8),
        .rn(rn8), .rm(rm8), .rd(rd8), .alu_op(op8), .shift(sh8), .asel(1'b0),
        .bsel(1'b0), .vsel(vsel8), .wb_en(1'b1), .set_flags(1'b1), .imm(imm8),
        .ext_in(ext8), .result(result8), .status(status8), .dbg_addr(dbg_addr8),
        .dbg_data(dbg_data8)
    );

    typedef struct {
        logic [AW-1:0] rn, rm, rd;
        logic [1:0]    op, sh;
        logic          asel, bsel, vsel, wb, sf;
        logic [IW-1:0] imm;
        logic [W-1:0]  ext;
    } cmd_t;

    typedef struct {
        logic [W-1:0]  res;
        logic [2:0]    st;
        logic [W-1:0]  rdval;
        int            cyc;
    } exp_t;

    exp_t       sbq[$];
    longint     mregs[N];
    longint     mc;
    logic [2:0] mst;
    int tests = 0, fails = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sgn(input longint x);
        longint h = longint'(1) << (W - 1);
        return (x >= h) ? x - 2 * h : x;
    endfunction

    // Reference model: plain modular arithmetic on the architectural state.
    task automatic model_exec(input cmd_t c, output exp_t e);
        longint m = longint'(1) << W;
        longint h = m / 2;
        longint a, b, r, s;
        logic   z, n, v;
        if (c.vsel) begin
            if (c.wb) mregs[c.rd] = c.ext;
        end else begin
            a = c.asel ? 0 : mregs[c.rn];
            b = mregs[c.rm];
            if (c.bsel)            b = c.imm;
            else if (c.sh == 2'd1) b = (b * 2) % m;
            else if (c.sh == 2'd2) b = b / 2;
            else if (c.sh == 2'd3) b = b / 2 + ((b >= h) ? h : 0);
            v = 1'b0;
            case (c.op)
                2'd0: begin r = (a + b) % m;     s = sgn(a) + sgn(b); v = (s >= h) || (s < -h); end
                2'd1: begin r = (a - b + m) % m; s = sgn(a) - sgn(b); v = (s >= h) || (s < -h); end
                2'd2: r = a & b;
                default: r = m - 1 - b;
            endcase
            z = (r == 0);
            n = (r >= h);
            mc = r;
`ifdef SEQ_DATAPATH_NV_FLAGS_EN
            if (c.sf) mst = {v, n, z};
`else
            if (c.sf) mst = {2'b00, z};
`endif
            if (c.wb) mregs[c.rd] = r;
        end
        e.res   = mc[W-1:0];
        e.st    = mst;
        e.rdval = mregs[c.rd][W-1:0];
        e.cyc   = 0;
    endtask

    function automatic cmd_t mk(input int rn_i, rm_i, rd_i, op_i, sh_i, asel_i, bsel_i,
                                vsel_i, wb_i, sf_i, imm_i, ext_i);
        cmd_t c;
        c.rn = AW'(rn_i); c.rm = AW'(rm_i); c.rd = AW'(rd_i);
        c.op = 2'(op_i);  c.sh = 2'(sh_i);
        c.asel = 1'(asel_i); c.bsel = 1'(bsel_i); c.vsel = 1'(vsel_i);
        c.wb = 1'(wb_i); c.sf = 1'(sf_i);
        c.imm = IW'(imm_i); c.ext = W'(ext_i);
        return c;
    endfunction

    task automatic drive(input cmd_t c);
        rn = c.rn; rm = c.rm; rd = c.rd; alu_op = c.op; shift = c.sh;
        asel = c.asel; bsel = c.bsel; vsel = c.vsel; wb_en = c.wb;
        set_flags = c.sf; imm = c.imm; ext_in = c.ext;
    endtask

    function automatic cmd_t rnd_cmd();
        return mk($urandom_range(0, N-1), $urandom_range(0, N-1), $urandom_range(0, N-1),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom, $urandom);
    endfunction

    // Issue one command; while busy, hammer start with garbage. Returns in the done cycle.
    task automatic issue(input cmd_t c);
        exp_t e;
        int   k = 0;
        while (!ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!ready) chk("ready_timeout", 0, 1);
        model_exec(c, e);
        drive(c);
        start = 1'b1;
        @(posedge clk); #1;
        e.cyc = cyc + (c.vsel ? 1 : 4);
        sbq.push_back(e);
        dbg_addr = c.rd;
        k = 0;
        while (!ready && k < 20) begin
            drive(rnd_cmd());
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (!ready) chk("busy_timeout", 0, 1);
    endtask

    task automatic run8(input logic v, input int rn_i, rm_i, rd_i, op_i, sh_i, ext_i);
        int k = 0;
        vsel8 = v; rn8 = 2'(rn_i); rm8 = 2'(rm_i); rd8 = 2'(rd_i);
        op8 = 2'(op_i); sh8 = 2'(sh_i); ext8 = 8'(ext_i);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        while (!done8 && k < 10) begin @(posedge clk); #1; k++; end
        if (!done8) chk("w8_done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sbq.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("status", status, e.st);
                chk("rd_value", dbg_data, e.rdval);
                chk("done_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        int k;
        logic [2:0] add_st;
        for (int i = 0; i < N; i++) mregs[i] = 0;
        mc = 0; mst = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_result", result, 0);
        for (int i = 0; i < N; i++) begin dbg_addr = AW'(i); #1; chk("rst_reg", dbg_data, 0); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Narrow build: asr1 of 8'h80 then not; rd=3 must not alias rd=0
        run8(1'b1, 0, 0, 3, 0, 0, 8'h80);
        run8(1'b0, 0, 3, 2, 3, 3, 0);
        chk("w8_result", result8, 8'h3F);
        dbg_addr8 = 2'd2; #1; chk("w8_r2", dbg_data8, 8'h3F);
        dbg_addr8 = 2'd3; #1; chk("w8_r3", dbg_data8, 8'h80);
        dbg_addr8 = 2'd0; #1; chk("w8_r0", dbg_data8, 8'h00);

        issue(mk(0, 0, 3, 0, 0, 0, 0, 1, 1, 0, 0, 16'h1234));
        chk("load_r3", dbg_data, 16'h1234);
        chk("load_result", result, 16'h0000);
        issue(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 16'h7FFF));
        issue(mk(0, 0, 2, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0001));
        issue(mk(1, 2, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0));
`ifdef SEQ_DATAPATH_NV_FLAGS_EN
        add_st = 3'b110;
`else
        add_st = 3'b000;
`endif
        chk("add_result", result, 16'h8000);
        chk("add_r4", dbg_data, 16'h8000);
        chk("add_status", status, add_st);
        issue(mk(0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0008));
        issue(mk(0, 0, 6, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0004));
        issue(mk(5, 6, 7, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        chk("sub_result", result, 16'h0000);
        chk("sub_z", status[0], 1'b1);
        issue(mk(2, 2, 0, 0, 3, 1, 1, 0, 0, 0, 5'h1F, 0));
        chk("imm_result", result, 16'h001F);

        for (int i = 0; i < 300; i++) issue(rnd_cmd());

        // Reset while the command is in EXEC: nothing may retire or be written
        @(negedge clk);
        drive(mk(1, 2, 6, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) mregs[i] = 0;
        mc = 0; mst = 3'b000;
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_status", status, 0);
        chk("midrst_result", result, 0);
        dbg_addr = 3'd6; #1; chk("midrst_rd", dbg_data, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        dbg_addr = 3'd6; #1; chk("midrst_rd_after", dbg_data, 0);
        chk("midrst_idle", ready, 1);

        for (int i = 0; i < 40; i++) issue(rnd_cmd());

        k = 0;
        while (sbq.size() != 0 && k < 20) begin @(posedge clk); k++; end
        chk("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
